// File: rtl/freq_meter_pkg.sv
// Constants and state encoding shared by the frequency-meter blocks
// (calc stage, BCD converter, display driver).
package freq_meter_pkg;

    localparam int FREQ_W     = 34;
    localparam int BCD_DIGITS = 11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } state_t;

    // True when every in_w-bit value fits in `digits` BCD digits
    // (2**in_w < 10**digits), kept inside 64-bit arithmetic.
    function automatic bit widths_legal(int in_w, int digits);
        longint unsigned p10;
        p10 = 64'd1;
        if (in_w < 2 || in_w > 63 || digits < 1 || digits > 19) return 1'b0;
        for (int i = 0; i < digits; i++) p10 = p10 * 64'd10;
        return (64'd1 << in_w) < p10;
    endfunction

endpackage

// File: rtl/freq_bcd_conv_if.sv
// Bus between the frequency calc stage (master) and the BCD converter (slave).
// FREQ_BCD_LEAD_ZERO_BLANK_EN adds the per-digit `blank` flags.
interface freq_bcd_conv_if
    import freq_meter_pkg::*;
#(
    parameter int IN_W   = FREQ_W,
    parameter int DIGITS = BCD_DIGITS
);
    logic [IN_W-1:0]     freq;
    logic                freq_vld;
    logic [4*DIGITS-1:0] bcd;
    logic                bcd_vld;
    logic                busy;
`ifdef FREQ_BCD_LEAD_ZERO_BLANK_EN
    logic [DIGITS-1:0]   blank;

    modport master (output freq, freq_vld, input bcd, bcd_vld, busy, blank);
    modport slave  (input freq, freq_vld, output bcd, bcd_vld, busy, blank);
`else
    modport master (output freq, freq_vld, input bcd, bcd_vld, busy);
    modport slave  (input freq, freq_vld, output bcd, bcd_vld, busy);
`endif
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble cell: a BCD digit of 5 or more gets +3 before the next shift.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/freq_bcd_conv.sv
// Serial binary-to-BCD converter (one bit per clock) with a one-deep pending slot.
// FREQ_BCD_LEAD_ZERO_BLANK_EN adds registered leading-zero blanking flags.
//
// state   | meaning
// S_IDLE  | waiting for freq_vld
// S_SHIFT | adjust digits and shift one input bit per cycle
// S_DONE  | result cycle (bcd_vld high); restart from pending/new strobe if any
module freq_bcd_conv
    import freq_meter_pkg::*;
#(
    parameter int IN_W   = FREQ_W,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    freq_bcd_conv_if.slave bus
);
    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

    if (!widths_legal(IN_W, DIGITS)) begin : g_bad_params
        $error("freq_bcd_conv: 2**IN_W must be below 10**DIGITS");
    end

    state_t              state_q;
    logic [IN_W-1:0]     shift_q;
    logic [ACC_W-1:0]    acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [IN_W-1:0]     pend_q;
    logic                pend_vld_q;
    logic [ACC_W-1:0]    bcd_q;
    logic                bcd_vld_q;
    logic                busy_q;

    logic [ACC_W-1:0]      acc_adj;
    logic [ACC_W+IN_W-1:0] work;
    logic [ACC_W-1:0]      acc_next;
    logic [IN_W-1:0]       shift_next;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (acc_q[4*i +: 4]),
            .dout (acc_adj[4*i +: 4])
        );
    end

    // The accumulator MSB is never set for legal widths, so dropping it is safe.
    assign work       = {acc_adj, shift_q} << 1;
    assign acc_next   = work[ACC_W+IN_W-1:IN_W];
    assign shift_next = work[IN_W-1:0];

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            bcd_q      <= '0;
            bcd_vld_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            bcd_vld_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.freq_vld) begin
                        shift_q <= bus.freq;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bus.freq_vld) begin
                        pend_q     <= bus.freq;
                        pend_vld_q <= 1'b1;
                    end
                    shift_q <= shift_next;
                    acc_q   <= acc_next;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        bcd_q     <= acc_next;
                        bcd_vld_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    // A strobe arriving now is newer than anything pending, so it wins.
                    if (bus.freq_vld || pend_vld_q) begin
                        shift_q    <= bus.freq_vld ? bus.freq : pend_q;
                        pend_vld_q <= 1'b0;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_SHIFT;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.bcd     = bcd_q;
    assign bus.bcd_vld = bcd_vld_q;
    assign bus.busy    = busy_q;

`ifdef FREQ_BCD_LEAD_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_next;
    logic [DIGITS-1:0] blank_q;
    logic              all_zero;

    // Walk down from the top digit; digit 0 is always shown.
    always_comb begin
        blank_next = '0;
        all_zero   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero      = all_zero && (acc_next[4*i +: 4] == 4'd0);
            blank_next[i] = all_zero;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            blank_q <= '0;
        end else if (state_q == S_SHIFT && cnt_q == CNT_LAST) begin
            blank_q <= blank_next;
        end
    end

    assign bus.blank = blank_q;
`endif

endmodule

// File: tb/tb_freq_bcd_conv.sv
// Scoreboard bench for freq_bcd_conv: stimulus pushes expected results,
// a negedge monitor pops and compares on every bcd_vld.
module tb_freq_bcd_conv;
    import freq_meter_pkg::*;

    localparam int IN_W   = FREQ_W;
    localparam int DIGITS = BCD_DIGITS;

    typedef struct {
        logic [4*DIGITS-1:0] bcd;
        logic [DIGITS-1:0]   blank;
        int                  cyc;
    } exp_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    freq_bcd_conv_if #(.IN_W(IN_W), .DIGITS(DIGITS)) bus ();

    freq_bcd_conv #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #10 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge sys_clk) begin
        if (bus.bcd_vld === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_bcd_vld", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("bcd", 64'(bus.bcd), 64'(e.bcd));
                check("latency_cycle", 64'(cyc), 64'(e.cyc));
`ifdef FREQ_BCD_LEAD_ZERO_BLANK_EN
                check("blank", 64'(bus.blank), 64'(e.blank));
`endif
            end
        end
    end

    // Called at a negedge; the strobe is sampled at the next posedge.
    task automatic expect_result(logic [4*DIGITS-1:0] bcd, logic [DIGITS-1:0] blank, int delay);
        exp_t e;
        e.bcd   = bcd;
        e.blank = blank;
        e.cyc   = cyc + delay;
        sb.push_back(e);
    endtask

    task automatic strobe(logic [IN_W-1:0] v);
        bus.freq     = v;
        bus.freq_vld = 1'b1;
        @(negedge sys_clk);
        bus.freq_vld = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic convert(logic [IN_W-1:0] v, logic [4*DIGITS-1:0] bcd, logic [DIGITS-1:0] blank);
        expect_result(bcd, blank, 35);
        strobe(v);
        drain();
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        bus.freq     = '0;
        bus.freq_vld = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("rst_bcd", 64'(bus.bcd), 64'd0);
        check("rst_bcd_vld", 64'(bus.bcd_vld), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
`ifdef FREQ_BCD_LEAD_ZERO_BLANK_EN
        check("rst_blank", 64'(bus.blank), 64'd0);
`endif
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);

        convert(34'd0, 44'h000_0000_0000, 11'b111_1111_1110);

        // busy window check on 12345678
        expect_result(44'h000_1234_5678, 11'b111_0000_0000, 35);
        strobe(34'd12345678);
        busy_cnt = 0;
        for (int i = 0; i < 34; i++) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(negedge sys_clk);
        end
        check("busy_cycles", 64'(busy_cnt), 64'd34);
        check("busy_low_on_vld", 64'(bus.busy), 64'd0);
        check("vld_with_busy_low", 64'(bus.bcd_vld), 64'd1);
        drain();

        convert(34'd17179869183, 44'h171_7986_9183, 11'b000_0000_0000);
        convert(34'd99,          44'h000_0000_0099, 11'b111_1111_1100);
        convert(34'd10000000000, 44'h100_0000_0000, 11'b000_0000_0000);
        convert(34'd9999999999,  44'h099_9999_9999, 11'b100_0000_0000);

        // pending: 2000 is overwritten by 3000 before the first result
        expect_result(44'h000_0000_1000, 11'b111_1111_0000, 35);
        expect_result(44'h000_0000_3000, 11'b111_1111_0000, 70);
        strobe(34'd1000);
        repeat (4) @(negedge sys_clk);
        strobe(34'd2000);
        repeat (4) @(negedge sys_clk);
        strobe(34'd3000);
        drain();
        check("bcd_holds", 64'(bus.bcd), 64'h3000);

        // asynchronous reset in the middle of a conversion of 9999
        strobe(34'd9999);
        repeat (9) @(negedge sys_clk);
        @(posedge sys_clk);
        #3 sys_rst = 1'b1;
        #1;
        check("midrst_bcd", 64'(bus.bcd), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_bcd_vld", 64'(bus.bcd_vld), 64'd0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (40) @(negedge sys_clk);
        check("post_rst_bcd", 64'(bus.bcd), 64'd0);

        convert(34'd42, 44'h000_0000_0042, 11'b111_1111_1100);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/freq_bcd_conv.md
Name: freq_bcd_conv

Overview:
- Downstream of the frequency-meter calculation stage; consumes its 34-bit binary `freq` result.
- Converts `freq` to packed BCD digits for the segment-display driver.
- Sequential shift-add-3 (double-dabble) converter with a one-deep pending buffer; takes one bit per clock.

Parameters:
- IN_W, 34, width of binary input; 2^IN_W must be < 10^DIGITS.
- DIGITS, 11, number of BCD digits produced (4 bits each).

Ports:
- sys_clk  input  1  system clock (50 MHz).
- sys_rst  input  1  asynchronous reset, active-high.
- freq  input  IN_W  binary frequency from calc stage.
- freq_vld  input  1  one-cycle strobe; `freq` is valid in that cycle.
- bcd  output  4*DIGITS  packed BCD; digit 0 (units) in [3:0].
- bcd_vld  output  1  one-cycle pulse; `bcd` updated in the same cycle.
- busy  output  1  high while a conversion is in progress.

Behaviour:
- Reset (async, sys_rst=1): state=IDLE; bcd=0, bcd_vld=0, busy=0; shift/BCD working regs cleared; pending flag cleared. Released synchronously to sys_clk.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - On freq_vld=1 at edge T: load `freq` into shift reg, clear BCD accumulator, bit counter=0, go to SHIFT.
  - busy goes high from T+1.
- SHIFT, one cycle per input bit, IN_W cycles:
  - Each cycle, every BCD digit >=5 gets +3 (combinational), then {acc,shift} shifts left 1.
  - Counter == IN_W-1 -> DONE.
- DONE, one cycle:
  - bcd <= acc; bcd_vld=1 during this cycle; busy=0.
  - If pending flag set: load the pending value, clear the flag, go to SHIFT. Otherwise go to IDLE.
- Latency: freq_vld sampled at edge T -> bcd_vld high in cycle T+IN_W+1 (35 cycles at default). Throughput is one result per IN_W+1 cycles.
- freq_vld while busy (SHIFT or DONE): value captured into the pending reg and the pending flag set. A later strobe overwrites it (newest wins; intermediate values dropped).
  - A strobe in DONE together with an existing pending value: the new strobe value wins.
- freq_vld in the same cycle as bcd_vld from IDLE->SHIFT entry: not possible (DONE handles it as pending).
- bcd holds its last value between conversions; it is never partially updated.
- Reset mid-conversion: aborts immediately; bcd returns to 0; pending discarded; no bcd_vld.
- Width rule: accumulator is 4*DIGITS bits. No overflow is possible for legal parameter pairs; parameter legality is checked at elaboration.

Optional Feature:
- Macro: FREQ_BCD_LEAD_ZERO_BLANK_EN.
- With it defined:
  - Extra output `blank` [DIGITS-1:0], registered alongside `bcd` and updated with bcd_vld.
  - blank[i]=1 when digit i and all higher digits are zero.
  - Digit 0 is never blanked; value 0 -> blank = all ones except bit 0.
  - Reset value 0.
- Without it: `blank` port absent; no leading-zero logic synthesized.

Decomposition:
- Shared package freq_meter_pkg:
  - FREQ_W=34 and BCD_DIGITS=11 constants, also used by the calc stage and display driver.
  - State encoding localparams ST_IDLE=0, ST_SHIFT=1, ST_DONE=2.
- Sub-module bcd_digit_adj: 4-bit in/out, the add-3-if->=5 cell, instantiated DIGITS times via generate.

Test Plan:
- Reset, then freq=0, freq_vld pulse -> bcd_vld exactly 35 cycles later, bcd=44'h000_0000_0000.
- freq=12345678 -> bcd=44'h000_1234_5678; busy high for 34 cycles, low on bcd_vld cycle.
- freq=17179869183 (all ones) -> bcd=44'h171_7986_9183.
- Strobe 1000 at T, strobes 2000 and 3000 during SHIFT -> two bcd_vld pulses, values 0x1000 then 0x3000; 2000 never appears; second bcd_vld 35 cycles after the first.
- Assert sys_rst asynchronously (mid-cycle) at conversion cycle 10 of 9999 -> bcd=0, busy=0 immediately; no bcd_vld after release; a fresh strobe of 42 yields bcd=0x42.
- With FREQ_BCD_LEAD_ZERO_BLANK_EN defined: freq=1000 -> blank=11'b111_1111_0000; freq=0 -> blank=11'b111_1111_1110.
